// File: rtl/write_ddr_pack_pkg.sv
// Shared constants, the flush state type and a level-width helper for the
// DDR write-path packing FIFO.
package write_ddr_pack_pkg;

    // Default configuration: 32-bit words packed into 256-bit beats, 16 beats deep.
    localparam int WR_DATA_WIDTH_DEF  = 32;
    localparam int RD_DATA_WIDTH_DEF  = 256;
    localparam int RD_DEPTH_WIDTH_DEF = 4;
    localparam int RATIO              = RD_DATA_WIDTH_DEF / WR_DATA_WIDTH_DEF;
    localparam int RATIO_LOG2         = $clog2(RATIO);
    localparam int DEPTH              = 1 << RD_DEPTH_WIDTH_DEF;
    localparam int WR_LEVEL_W         = RD_DEPTH_WIDTH_DEF + RATIO_LOG2 + 1;
    localparam int RD_LEVEL_W         = RD_DEPTH_WIDTH_DEF + 1;

    // Flush controller: either nothing owed, or a partial beat waiting for room.
    typedef enum logic {
        FLUSH_IDLE    = 1'b0,
        FLUSH_PENDING = 1'b1
    } flush_state_t;

    // Width of the input-word occupancy count for a given configuration.
    function automatic int wr_level_width(input int depth_width,
                                          input int rd_width,
                                          input int wr_width);
        return depth_width + $clog2(rd_width / wr_width) + 1;
    endfunction

endpackage

// File: rtl/write_ddr_pack_ram.sv
// Simple dual-port beat storage: one write port, one read port with a
// registered output that holds its value between reads.
module write_ddr_pack_ram #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // Write port: store a committed beat.
    // NOTE: the storage array has no reset; emptiness is tracked by the
    // controller's counters, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, cleared by reset, held when not reading.
    // A read and write to the same address return the old beat, which is
    // exactly the oldest entry when the store is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/write_ddr_pack_fifo.sv
// DDR write-path gearbox: packs narrow user words into wide DDR beats, queues
// committed beats for the burst engine, and supports flushing a partial beat.
module write_ddr_pack_fifo
    import write_ddr_pack_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = 32,
    parameter int RD_DATA_WIDTH    = 256,
    parameter int RD_DEPTH_WIDTH   = 4,
    parameter int ALMOST_FULL_NUM  = 120,
    parameter int ALMOST_EMPTY_NUM = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [wr_level_width(RD_DEPTH_WIDTH, RD_DATA_WIDTH, WR_DATA_WIDTH)-1:0] wr_water_level,
    input  logic                     flush,
    output logic                     flush_busy,
    input  logic                     rd_en,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [RD_DEPTH_WIDTH:0]  rd_water_level
);

    // Words per beat must be a power of two of at least 2, so the input-word
    // level is simply {beat count, slot index}.
    localparam int PACK_RATIO = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam int PACK_W     = $clog2(PACK_RATIO);
    localparam int MEM_DEPTH  = 1 << RD_DEPTH_WIDTH;
    localparam int CNT_W      = RD_DEPTH_WIDTH + 1;
    localparam int WL_W       = CNT_W + PACK_W;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(MEM_DEPTH);
    localparam logic [PACK_W-1:0] SLOT_LAST = PACK_W'(PACK_RATIO - 1);
    localparam logic [WL_W-1:0]   AF_LEVEL  = WL_W'(ALMOST_FULL_NUM);
    localparam logic [CNT_W-1:0]  AE_LEVEL  = CNT_W'(ALMOST_EMPTY_NUM);

    logic [RD_DEPTH_WIDTH-1:0] wptr;
    logic [RD_DEPTH_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]          mem_count;
    logic [PACK_W-1:0]         pack_cnt;
    logic [PACK_W-1:0]         pack_cnt_d;
    logic [RD_DATA_WIDTH-1:0]  pack;
    logic [RD_DATA_WIDTH-1:0]  pack_d;
    logic [RD_DATA_WIDTH-1:0]  pack_ins;
    flush_state_t              state;
    flush_state_t              state_d;

    logic wr_acc;
    logic rd_acc;
    logic commit;
    logic mem_full;
    logic slot_last;

    // Status derived purely from registered state.
    assign mem_full       = (mem_count == CNT_FULL);
    assign slot_last      = (pack_cnt == SLOT_LAST);
    assign wr_full        = (mem_full && slot_last) || (state == FLUSH_PENDING);
    assign rd_empty       = (mem_count == '0);
    assign wr_acc         = wr_en && !wr_full;
    assign rd_acc         = rd_en && !rd_empty;
    assign flush_busy     = (state == FLUSH_PENDING);
    assign rd_water_level = mem_count;
    assign wr_water_level = {mem_count, pack_cnt};
    assign almost_full    = (wr_water_level >= AF_LEVEL);
    assign almost_empty   = (mem_count <= AE_LEVEL);

    // Gearbox: drop an accepted word into its slot; word 0 lands in the LSBs.
    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        pack_ins = pack;
        if (wr_acc) begin
            pack_ins[int'(pack_cnt) * WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
        end
    end

    // Flush FSM next state plus commit decision and next pack state.
    always_comb begin
        state_d    = state;
        commit     = 1'b0;
        pack_d     = pack_ins;
        pack_cnt_d = wr_acc ? pack_cnt + 1'b1 : pack_cnt;

        case (state)
            FLUSH_IDLE: begin
                if (wr_acc && slot_last) begin
                    // A completed beat commits once, even if flush arrives with it.
                    commit = 1'b1;
                end else if (flush && ((pack_cnt != '0) || wr_acc)) begin
                    if (!mem_full) begin
                        commit = 1'b1;
                    end else begin
                        state_d = FLUSH_PENDING;
                    end
                end
            end
            FLUSH_PENDING: begin
                // Waits on the registered count, so a same-cycle read does not help.
                if (!mem_full) begin
                    commit  = 1'b1;
                    state_d = FLUSH_IDLE;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase

        if (commit) begin
            pack_d     = '0;
            pack_cnt_d = '0;
        end
    end

    // Flush FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FLUSH_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Pack register, pointers and beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack      <= '0;
            pack_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
        end else begin
            pack     <= pack_d;
            pack_cnt <= pack_cnt_d;
            if (commit) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({commit, rd_acc})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    write_ddr_pack_ram #(
        .DATA_WIDTH (RD_DATA_WIDTH),
        .ADDR_WIDTH (RD_DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (commit),
        .wr_addr (wptr),
        .wr_data (pack_ins),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_write_ddr_pack_fifo.sv
// Directed bench for write_ddr_pack_fifo: packing order, flush padding,
// full/pending behaviour, water levels, flags and mid-stream reset.
module tb_write_ddr_pack_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [31:0]  wr_data;
    logic         wr_full;
    logic         almost_full;
    logic [7:0]   wr_water_level;
    logic         flush;
    logic         flush_busy;
    logic         rd_en;
    logic [255:0] rd_data;
    logic         rd_empty;
    logic         almost_empty;
    logic [4:0]   rd_water_level;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    write_ddr_pack_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .almost_full    (almost_full),
        .wr_water_level (wr_water_level),
        .flush          (flush),
        .flush_busy     (flush_busy),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .almost_empty   (almost_empty),
        .rd_water_level (rd_water_level)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Expected beat: nwords consecutive words from base, LSB first, rest zero.
    function automatic logic [255:0] beat(input logic [31:0] base, input int nwords);
        logic [255:0] b = '0;
        for (int k = 0; k < nwords; k++) begin
            b[k*32 +: 32] = base + 32'(k);
        end
        return b;
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rd_empty", 256'(rd_empty), 256'(1));
        check("rst_almost_empty", 256'(almost_empty), 256'(1));
        check("rst_wr_full", 256'(wr_full), 256'(0));
        check("rst_almost_full", 256'(almost_full), 256'(0));
        check("rst_flush_busy", 256'(flush_busy), 256'(0));
        check("rst_wr_level", 256'(wr_water_level), 256'(0));
        check("rst_rd_level", 256'(rd_water_level), 256'(0));
        check("rst_rd_data", rd_data, 256'(0));

        // One full beat of words 1..8
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'(i + 1);
            tick();
            if (i == 6) begin
                check("t1_empty_at7", 256'(rd_empty), 256'(1));
                check("t1_wrlvl_at7", 256'(wr_water_level), 256'(7));
            end
        end
        wr_en = 1'b0;
        check("t1_rd_empty", 256'(rd_empty), 256'(0));
        check("t1_rd_level", 256'(rd_water_level), 256'(1));
        check("t1_wr_level", 256'(wr_water_level), 256'(8));
        pop();
        check("t1_rd_data", rd_data,
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        check("t1_rd_level_after", 256'(rd_water_level), 256'(0));
        check("t1_empty_after", 256'(rd_empty), 256'(1));

        // Partial beat flushed with zero padding
        push(32'hA); push(32'hB); push(32'hC);
        check("t2_wr_level", 256'(wr_water_level), 256'(3));
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_rd_level", 256'(rd_water_level), 256'(1));
        check("t2_wr_level_flushed", 256'(wr_water_level), 256'(8));
        check("t2_flush_busy", 256'(flush_busy), 256'(0));
        pop();
        check("t2_rd_data", rd_data, {160'h0, 32'hC, 32'hB, 32'hA});
        check("t2_wr_level_after", 256'(wr_water_level), 256'(0));
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_empty_flush_lvl", 256'(rd_water_level), 256'(0));
        check("t2_empty_flush_busy", 256'(flush_busy), 256'(0));

        // Fill 16 beats + 7 words, with flag boundaries along the way
        for (int i = 0; i < 135; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
            tick();
            if (i == 7)   check("t3_ae_lvl1", 256'(almost_empty), 256'(1));
            if (i == 15)  check("t3_ae_lvl2", 256'(almost_empty), 256'(0));
            if (i == 118) check("t3_af_119", 256'(almost_full), 256'(0));
            if (i == 119) check("t3_af_120", 256'(almost_full), 256'(1));
        end
        wr_en = 1'b0;
        check("t3_wr_full", 256'(wr_full), 256'(1));
        check("t3_almost_full", 256'(almost_full), 256'(1));
        check("t3_wr_level", 256'(wr_water_level), 256'(135));
        check("t3_rd_level", 256'(rd_water_level), 256'(16));
        // Read and write together: the write is refused since wr_full ignores rd_en
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h187;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("t3_rd_data0", rd_data, beat(32'h100, 8));
        check("t3_rd_level_15", 256'(rd_water_level), 256'(15));
        check("t3_wr_level_127", 256'(wr_water_level), 256'(127));
        check("t3_wr_full_drop", 256'(wr_full), 256'(0));
        push(32'h187);
        check("t3_rd_level_16", 256'(rd_water_level), 256'(16));
        check("t3_wr_level_128", 256'(wr_water_level), 256'(128));
        check("t3_wr_full_slot0", 256'(wr_full), 256'(0));
        for (int j = 1; j <= 16; j++) begin
            pop();
            check($sformatf("t3_drain_%0d", j), rd_data, beat(32'h100 + 32'(8 * j), 8));
        end
        check("t3_empty", 256'(rd_empty), 256'(1));
        pop();
        check("t3_underflow_data", rd_data, beat(32'h180, 8));
        check("t3_underflow_lvl", 256'(rd_water_level), 256'(0));

        // Flush while the store is full: pending until a read frees a slot
        for (int i = 0; i < 133; i++) begin
            wr_en = 1'b1; wr_data = 32'h200 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t4_wr_full_pre", 256'(wr_full), 256'(0));
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_flush_busy", 256'(flush_busy), 256'(1));
        check("t4_wr_full", 256'(wr_full), 256'(1));
        check("t4_rd_level", 256'(rd_water_level), 256'(16));
        wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        wr_en = 1'b0; flush = 1'b0;
        check("t4_blocked_lvl", 256'(wr_water_level), 256'(133));
        check("t4_busy_hold", 256'(flush_busy), 256'(1));
        pop();
        check("t4_rd_data0", rd_data, beat(32'h200, 8));
        check("t4_rd_level_15", 256'(rd_water_level), 256'(15));
        check("t4_busy_after_rd", 256'(flush_busy), 256'(1));
        tick();
        check("t4_rd_level_16", 256'(rd_water_level), 256'(16));
        check("t4_busy_clear", 256'(flush_busy), 256'(0));
        check("t4_wr_full_clear", 256'(wr_full), 256'(0));
        check("t4_wr_level", 256'(wr_water_level), 256'(128));
        for (int j = 1; j <= 16; j++) begin
            pop();
            check($sformatf("t4_drain_%0d", j), rd_data,
                  beat(32'h200 + 32'(8 * j), (j == 16) ? 5 : 8));
        end

        // Flush coinciding with the 8th word: exactly one unpadded beat
        for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
        wr_en = 1'b1; wr_data = 32'h307; flush = 1'b1;
        tick();
        wr_en = 1'b0; flush = 1'b0;
        check("t5_rd_level", 256'(rd_water_level), 256'(1));
        check("t5_wr_level", 256'(wr_water_level), 256'(8));
        check("t5_flush_busy", 256'(flush_busy), 256'(0));
        tick();
        tick();
        check("t5_no_double", 256'(rd_water_level), 256'(1));
        pop();
        check("t5_rd_data", rd_data, beat(32'h300, 8));
        check("t5_rd_level_after", 256'(rd_water_level), 256'(0));

        // Reset in the middle of a stream discards everything
        for (int i = 0; i < 34; i++) push(32'h400 + 32'(i));
        check("t6_rd_level", 256'(rd_water_level), 256'(4));
        check("t6_wr_level", 256'(wr_water_level), 256'(34));
        pop();
        check("t6_rd_data", rd_data, beat(32'h400, 8));
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_wr_level_rst", 256'(wr_water_level), 256'(0));
        check("t6_rd_level_rst", 256'(rd_water_level), 256'(0));
        check("t6_empty_rst", 256'(rd_empty), 256'(1));
        check("t6_ae_rst", 256'(almost_empty), 256'(1));
        check("t6_rd_data_rst", rd_data, 256'(0));
        pop();
        check("t6_rd_ignored_lvl", 256'(rd_water_level), 256'(0));
        check("t6_rd_ignored_data", rd_data, 256'(0));
        for (int i = 0; i < 8; i++) push(32'h500 + 32'(i));
        pop();
        check("t6_clean_beat", rd_data, beat(32'h500, 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/write_ddr_pack_fifo.md
Name: write_ddr_pack_fifo

Overview:
- Single-clock width-converting buffer on the DDR write path.
- Packs 32-bit user words into 256-bit DDR beats and queues them for the DDR write-burst engine.
- Mirror of the DDR read path, which unpacks 256-bit DDR data to 32-bit.
- Provides flush (zero-pad a partial beat), water levels and almost flags for burst scheduling.

Parameters:
- WR_DATA_WIDTH, 32: input word width.
- RD_DATA_WIDTH, 256: output beat width. RATIO = RD/WR must be a power of two (default 8).
- RD_DEPTH_WIDTH, 4: log2 of beat storage depth (16 beats).
- ALMOST_FULL_NUM, 120: almost_full threshold, in input words.
- ALMOST_EMPTY_NUM, 1: almost_empty threshold, in beats.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WR_DATA_WIDTH  input word.
- wr_full  out  1  write not accepted this cycle.
- almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
- wr_water_level  out  RD_DEPTH_WIDTH+log2(RATIO)+1  occupancy in input words.
- flush  in  1  single-cycle pulse: commit partial beat.
- flush_busy  out  1  flush pending.
- rd_en  in  1  read request.
- rd_data  out  RD_DATA_WIDTH  output beat.
- rd_empty  out  1  no committed beat.
- almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.
- rd_water_level  out  RD_DEPTH_WIDTH+1  committed beats.

Behaviour:
- Reset (sync, rst=1 at edge): pointers, mem_count, pack_cnt, pack register and flush_pending cleared.
  - rd_data=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, flush_busy=0, both levels 0.
  - Reset mid-operation discards all data, including a partial beat.
- Write accept: wr_acc = wr_en & ~wr_full.
  - Word k of a beat goes to pack bits [k*32+31:k*32], so the first word lands in the LSBs.
  - pack_cnt increments modulo RATIO.
- Commit:
  - Triggered on the edge where wr_acc and pack_cnt==RATIO-1.
  - The beat (including the current word) is written to mem[wptr]; wptr++ and mem_count++.
  - The pack register is cleared to 0.
- wr_full is combinational from registered state only:
  - asserted when (mem_count==DEPTH and pack_cnt==RATIO-1) or flush_pending.
  - It does not look at same-cycle rd_en.
- Flush, on a flush pulse or while flush_pending:
  - pack_cnt==0 and no wr_acc: no-op; flush_pending stays 0.
  - mem_count<DEPTH: commit the pack register with unwritten slots zero; pack_cnt=0; flush_pending=0.
  - mem_count==DEPTH: set flush_pending. Commit on the first cycle with mem_count<DEPTH (a same-cycle read does not count).
  - flush and wr_acc in the same cycle: the word is included first, then the beat commits once (no double commit when the word completes the beat).
  - flush while flush_pending: ignored.
  - flush_busy = flush_pending.
- Read: rd_acc = rd_en & ~rd_empty.
  - rd_data <= mem[rptr] on that edge (1-cycle latency, no output register); rptr++ and mem_count--.
  - rd_data holds its value otherwise.
  - rd_en while empty: ignored, no underflow.
- Simultaneous commit and read: mem_count unchanged and both pointers advance. Legal even when mem_count==DEPTH, because wr_full already gated the write.
- Pointers are RD_DEPTH_WIDTH bits and wrap naturally; mem_count is RD_DEPTH_WIDTH+1 bits (0..DEPTH).
- Status outputs:
  - rd_empty = (mem_count==0).
  - rd_water_level = mem_count.
  - wr_water_level = mem_count*RATIO + pack_cnt.
  - Flags derive from registered counts, so they are valid the cycle after the causing edge.

Decomposition:
- Package write_ddr_pack_pkg: RATIO, RATIO_LOG2 (clog2), DEPTH localparams; level-width constants.
- Sub-module write_ddr_pack_ram: simple dual-port, write-first-irrelevant synchronous RAM, RD_DATA_WIDTH x DEPTH, one write port and one read port with registered read. The top level holds the gearbox, counters, flush FSM (IDLE/PENDING) and flags.

Test Plan:
- Write 8 words 0x00000001..0x00000008, then rd_en -> rd_empty deasserts the cycle after the 8th write; rd_data = 0x00000008_00000007_..._00000001 one cycle after rd_en; rd_water_level 1->0.
- Write 3 words 0xA,0xB,0xC, then pulse flush -> one beat committed = {160'h0, 0xC, 0xB, 0xA}; pack_cnt 0; wr_water_level 0 after the read.
- Fill 16 beats + 7 words -> wr_full=1, almost_full=1, wr_water_level=135. One rd_en -> wr_full drops next cycle; the 8th word commits; rd_water_level stays 16.
- Full memory with 5 buffered words, then flush -> flush_busy=1 and wr_full=1. After one read, the zero-padded beat commits the next cycle; flush_busy=0.
- flush in the same cycle as the 8th word -> exactly one beat committed with no zero slots; rd_water_level increments by 1.
- rst asserted mid-stream (4 beats + 2 words) -> next cycle all levels 0, rd_empty=1, rd_data=0; rd_en afterwards is ignored.
